dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Word-addressed memory responder for the data-cache memory port: it answers the cache's `mem_rdreq` with a burst of `mem_burstlen` words and absorbs `mem_wrreq` word writes, one per cycle.

- Backing store is an internal synchronous RAM.
- Sits directly behind the data cache in simulation and FPGA bring-up builds.
- Serves as the far end of the cache fill/flush protocol until the external memory controller replaces it.

## Interface
Parameters:
- `DATABITS`, 32, data word width.
- `ADDRBITS`, 32, byte address width.
- `MEMWORDBITS`, 10, log2 of RAM depth in words (default 1024 words).
- `BURSTLEN`, 8, words returned per read request; legal range 1..65535.
- `READLATENCY`, 2, idle cycles between request acceptance and first beat; 0..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_addr` in `ADDRBITS`: byte address of a read-burst start or of a write word.
- `mem_in` in `DATABITS`: write data.
- `mem_out` out `DATABITS`: read beat data.
- `mem_out_valid` out 1: `mem_out` holds a valid beat this cycle.
- `mem_rdreq` in 1: read-burst request, sampled as a level each cycle.
- `mem_wrreq` in 1: word write, sampled as a level each cycle.
- `mem_burstlen` out 16: constant `BURSTLEN`, driven combinationally, also during reset.

## Operation
- Word index is `mem_addr[MEMWORDBITS+1:2]`. `mem_addr[1:0]` and the bits above `MEMWORDBITS+1` are ignored, so addresses alias modulo RAM size.
- Writes:
  - Every rising edge with `mem_wrreq`=1 writes `mem_in` to the word index, in any state.
  - No byte enables; the whole word is written.
- Read FSM:
  - IDLE:
    - `mem_rdreq`=1 latches the start word index into `beat_idx` and clears `cnt_beat`.
    - Goes to LAT with `cnt_lat`=`READLATENCY`, or straight to BURST when `READLATENCY`=0.
  - LAT:
    - `cnt_lat` decrements each cycle.
    - When it reaches 1, goes to BURST.
  - BURST:
    - Each beat registers RAM[`beat_idx`] into `mem_out` and asserts `mem_out_valid`.
    - Each beat increments `beat_idx` (wraps at 2^`MEMWORDBITS`) and `cnt_beat`.
    - After beat number `BURSTLEN`, returns to IDLE.
- `mem_rdreq` is ignored outside IDLE. It is not queued.
- Read-before-write: a beat and a write to the same word in the same cycle return the old data. A write to a word that has not yet been beaten is visible in its later beat.
- `mem_out` keeps its last beat value when `mem_out_valid`=0; it does not return to zero.

## Timing
- Reset values: `mem_out`=0, `mem_out_valid`=0, FSM=IDLE, `cnt_lat`=0, `cnt_beat`=0, `beat_idx`=0. RAM contents are not reset.
- Request sampled at edge E0:
  - `mem_out_valid` is high during cycles E0+`READLATENCY`+1 through E0+`READLATENCY`+`BURSTLEN`.
  - These beats are back-to-back.
- IDLE is reached in the cycle after the last beat. A new `mem_rdreq` is accepted there at the earliest, which gives a minimum gap of one cycle between bursts.
- Simultaneous `mem_rdreq` and `mem_wrreq` in IDLE: both are performed. If the write hits the burst start word, beat 1 sees the new data whenever `READLATENCY`≥1 (RAM is read one cycle later).
- Reset asserted mid-burst: `mem_out_valid` drops immediately (asynchronously) and the remaining beats are discarded. After release the block is in IDLE.
- Writes accepted at 1 word/cycle indefinitely; there is no backpressure signal.

## Configuration
- `DMEM_CTRL_WAITSTATE_EN` defined:
  - BURST inserts one idle cycle (`mem_out_valid`=0) after every beat except the last.
  - A burst then spans 2·`BURSTLEN`−1 cycles.
  - Exercises cache tolerance of gapped beats.
- `DMEM_CTRL_WAITSTATE_EN` undefined: beats are strictly back-to-back as specified above.

## Test plan
- Reset then idle → `mem_out_valid`=0, `mem_out`=0, `mem_burstlen`=8 throughout; no beats without a request.
- Write words 0x1000+4k (k=0..7) with data k·0x11111111; pulse `mem_rdreq` at 0x1000 → valid in cycles E0+3..E0+10 with data 0x00000000..0x77777777 in order.
- Burst starting at word index 1020 (byte 0xFF0) with `MEMWORDBITS`=10 → beats 5..8 return words 0..3 (wrap).
- `mem_rdreq` held high for 20 cycles → exactly two bursts: the second starts 1 cycle after IDLE is re-entered, with 8 beats each.
- During a burst, write beat-5's word before its beat and beat-2's word in the same cycle as its beat → beat 5 shows new data, beat 2 shows old data.
- Assert `reset_n` low during beat 4 → `mem_out_valid` low immediately, no further beats. A new request after release yields a full 8-beat burst with RAM contents intact.

Source files
------------

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Word-addressed memory responder for the data-cache memory port. A read
//   request returns a burst of BURSTLEN words from an internal synchronous RAM,
//   starting READLATENCY idle cycles after acceptance. Word writes are absorbed
//   one per cycle, in any state, without backpressure.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   mem_addr       in   byte address (burst start or write word)
//   mem_in         in   write data
//   mem_out        out  read beat data (holds last beat when not valid)
//   mem_out_valid  out  mem_out carries a beat this cycle
//   mem_rdreq      in   read-burst request, level-sampled, only honoured in IDLE
//   mem_wrreq      in   word write, level-sampled every cycle
//   mem_burstlen   out  constant BURSTLEN
//
// Configuration macro
//   DMEM_CTRL_WAITSTATE_EN : when defined, one idle cycle is inserted after
//   every beat except the last (burst spans 2*BURSTLEN-1 cycles).
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int DATABITS    = 32,
   parameter int ADDRBITS    = 32,
   parameter int MEMWORDBITS = 10,
   parameter int BURSTLEN    = 8,
   parameter int READLATENCY = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDRBITS-1:0] mem_addr,
   input  logic [DATABITS-1:0] mem_in,
   output logic [DATABITS-1:0] mem_out,
   output logic                mem_out_valid,
   input  logic                mem_rdreq,
   input  logic                mem_wrreq,
   output logic [15:0]         mem_burstlen
);

   localparam int DEPTH = 1 << MEMWORDBITS;
   localparam logic [15:0]            LAST_BEAT = 16'(BURSTLEN - 1);
   localparam logic [7:0]             LAT_INIT  = 8'(READLATENCY);
   localparam logic [MEMWORDBITS-1:0] IDX_ONE   = {{(MEMWORDBITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LAT   = 2'd1,
      S_BURST = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [MEMWORDBITS-1:0] word_idx_s;
   logic [MEMWORDBITS-1:0] beat_idx_r;
   logic [MEMWORDBITS-1:0] beat_idx_nxt_s;
   logic [7:0]             cnt_lat_r;
   logic [7:0]             cnt_lat_nxt_s;
   logic [15:0]            cnt_beat_r;
   logic [15:0]            cnt_beat_nxt_s;
   logic                   beat_en_s;
   logic [DATABITS-1:0]    mem_out_r;
   logic                   mem_out_valid_r;
   logic [DATABITS-1:0]    ram_r [0:DEPTH-1];
   logic                   unused_addr_s;

   // Addresses alias modulo RAM size: byte-offset and high bits are dropped.
   assign word_idx_s    = mem_addr[MEMWORDBITS+1:2];
   assign unused_addr_s = ^{mem_addr[ADDRBITS-1:MEMWORDBITS+2], mem_addr[1:0]};

   assign mem_burstlen  = 16'(BURSTLEN);
   assign mem_out       = mem_out_r;
   assign mem_out_valid = mem_out_valid_r;

   // Backing RAM write port; not reset, writes accepted in every state.
   always_ff @(posedge clk) begin
      if (mem_wrreq) begin
         ram_r[word_idx_s] <= mem_in;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Read FSM next-state and datapath next values.
   always_comb begin
      state_nxt_s    = state_r;
      beat_idx_nxt_s = beat_idx_r;
      cnt_lat_nxt_s  = cnt_lat_r;
      cnt_beat_nxt_s = cnt_beat_r;
      beat_en_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (mem_rdreq) begin
               beat_idx_nxt_s = word_idx_s;
               cnt_beat_nxt_s = 16'd0;
               cnt_lat_nxt_s  = LAT_INIT;
               if (LAT_INIT == 8'd0) begin
                  state_nxt_s = S_BURST;
               end else begin
                  state_nxt_s = S_LAT;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_LAT: begin
            // Leaving at a count of 1 yields exactly READLATENCY idle cycles.
            if (cnt_lat_r <= 8'd1) begin
               cnt_lat_nxt_s = 8'd0;
               state_nxt_s   = S_BURST;
            end else begin
               cnt_lat_nxt_s = cnt_lat_r - 8'd1;
               state_nxt_s   = S_LAT;
            end
         end
         S_BURST: begin
            beat_en_s      = 1'b1;
            beat_idx_nxt_s = beat_idx_r + IDX_ONE;
            cnt_beat_nxt_s = cnt_beat_r + 16'd1;
            if (cnt_beat_r == LAST_BEAT) begin
               state_nxt_s = S_IDLE;
            end else begin
`ifdef DMEM_CTRL_WAITSTATE_EN
               state_nxt_s = S_GAP;
`else
               state_nxt_s = S_BURST;
`endif
            end
         end
         S_GAP: begin
            state_nxt_s = S_BURST;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Datapath registers; the RAM read in a beat sees pre-write contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_idx_r      <= {MEMWORDBITS{1'b0}};
         cnt_lat_r       <= 8'd0;
         cnt_beat_r      <= 16'd0;
         mem_out_r       <= {DATABITS{1'b0}};
         mem_out_valid_r <= 1'b0;
      end else begin
         beat_idx_r      <= beat_idx_nxt_s;
         cnt_lat_r       <= cnt_lat_nxt_s;
         cnt_beat_r      <= cnt_beat_nxt_s;
         mem_out_valid_r <= beat_en_s;
         if (beat_en_s) begin
            mem_out_r <= ram_r[beat_idx_r];
         end
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl with default parameters. A behavioural
//   model (memory array plus burst timing computed from request edge numbers)
//   predicts mem_out_valid / mem_out every cycle; a vector table and directed
//   sequences cover the burst, wrap, back-to-back, read-before-write and reset
//   corner cases; a random phase exercises aliasing and mixed traffic.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

   localparam int DEPTH = 1024;
   localparam int BL    = 8;
   localparam int RL    = 2;
`ifdef DMEM_CTRL_WAITSTATE_EN
   localparam int STRIDE = 2;
`else
   localparam int STRIDE = 1;
`endif

   logic        clk;
   logic        reset_n;
   logic [31:0] mem_addr;
   logic [31:0] mem_in;
   logic [31:0] mem_out;
   logic        mem_out_valid;
   logic        mem_rdreq;
   logic        mem_wrreq;
   logic [15:0] mem_burstlen;

   dmem_ctrl #(
      .DATABITS(32), .ADDRBITS(32), .MEMWORDBITS(10), .BURSTLEN(BL), .READLATENCY(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_in(mem_in),
      .mem_out(mem_out), .mem_out_valid(mem_out_valid), .mem_rdreq(mem_rdreq),
      .mem_wrreq(mem_wrreq), .mem_burstlen(mem_burstlen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] din;
      logic        exp_v;
      logic [31:0] exp_d;
   } vec_t;

   vec_t        tbl [20];
   int          errs;
   int          checks;
   int          edge_n;
   int          b_first;
   int          b_last;
   int          b_start;
   logic [31:0] last_d;
   logic [31:0] mdl [DEPTH];
   logic [31:0] obs_q [$];

   function automatic logic [31:0] pat(input int i);
      return {16'hC0DE, 16'(i)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din);
      int   wi;
      int   bn;
      logic ev;
      mem_rdreq = rd;
      mem_wrreq = wr;
      mem_addr  = addr;
      mem_in    = din;
      @(posedge clk);
      edge_n++;
      wi = int'(addr[11:2]);
      ev = 1'b0;
      if (!reset_n) begin
         b_first = 0;
         b_last  = -1;
         last_d  = 32'h0;
      end else begin
         if (edge_n >= b_first && edge_n <= b_last && ((edge_n - b_first) % STRIDE) == 0) begin
            bn     = (edge_n - b_first) / STRIDE;
            ev     = 1'b1;
            last_d = mdl[(b_start + bn) % DEPTH];
         end
         if (rd && edge_n > b_last) begin
            b_first = edge_n + RL + 1;
            b_last  = b_first + (BL - 1) * STRIDE;
            b_start = wi;
         end
      end
      if (wr) mdl[wi] = din;
      #1;
      check("beat_valid", 32'(mem_out_valid), 32'(ev));
      check("beat_data", mem_out, last_d);
      if (mem_out_valid) obs_q.push_back(mem_out);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      errs      = 0;
      checks    = 0;
      edge_n    = 0;
      b_first   = 0;
      b_last    = -1;
      b_start   = 0;
      last_d    = 32'h0;
      reset_n   = 1'b0;
      mem_rdreq = 1'b0;
      mem_wrreq = 1'b0;
      mem_addr  = 32'h0;
      mem_in    = 32'h0;

      // Vector table: eight writes, one read pulse, then the expected burst.
      for (int k = 0; k < 8; k++)
         tbl[k] = '{1'b0, 1'b1, 32'h1000 + 32'(4 * k), 32'h11111111 * 32'(k), 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      for (int k = 0; k < 8; k++)
         tbl[11 + k] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11111111 * 32'(k)};
      tbl[19] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77777777};

      // Reset held, then idle: nothing comes out, burst length constant.
      #1;
      check("rst_valid", 32'(mem_out_valid), 32'h0);
      check("rst_data", mem_out, 32'h0);
      check("rst_burstlen", 32'(mem_burstlen), 32'd8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("idle_burstlen", 32'(mem_burstlen), 32'd8);
      end

      // Table-driven basic burst.
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
         check("tbl_valid", 32'(mem_out_valid), 32'(tbl[i].exp_v));
         check("tbl_data", mem_out, tbl[i].exp_d);
      end

      // Fill the whole RAM with a known pattern.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'(i * 4), pat(i));
      idle(2);

      // Burst wrapping past the top of the RAM.
      obs_q.delete();
      step(1'b1, 1'b0, 32'h0FF0, 32'h0);
      idle(14);
      check("wrap_count", 32'(obs_q.size()), 32'd8);
      if (obs_q.size() == 8)
         for (int k = 0; k < 8; k++) check("wrap_beat", obs_q[k], pat((1020 + k) % DEPTH));

      // Request held high: exactly two bursts.
      obs_q.delete();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 32'h0);
      idle(12);
      check("held_count", 32'(obs_q.size()), 32'd16);
      if (obs_q.size() == 16) check("held_second_first", obs_q[8], pat(0));

      // Writes during a burst: ahead of a beat vs. in the same cycle as it.
      obs_q.delete();
      step(1'b1, 1'b0, 32'd400, 32'h0);
      idle(2);
      step(1'b0, 1'b1, 32'd416, 32'h5555AAAA);
      step(1'b0, 1'b1, 32'd404, 32'h2222BBBB);
      idle(10);
      check("rbw_count", 32'(obs_q.size()), 32'd8);
      if (obs_q.size() == 8) begin
         check("rbw_beat2_old", obs_q[1], pat(101));
         check("rbw_beat5_new", obs_q[4], 32'h5555AAAA);
      end

      // Reset during beat 4, then a full burst with RAM intact.
      obs_q.delete();
      step(1'b1, 1'b0, 32'd800, 32'h0);
      idle(6);
      check("midrst_pre_count", 32'(obs_q.size()), 32'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_valid_drop", 32'(mem_out_valid), 32'h0);
      check("midrst_data_clear", mem_out, 32'h0);
      idle(3);
      reset_n = 1'b1;
      obs_q.delete();
      step(1'b1, 1'b0, 32'd800, 32'h0);
      idle(12);
      check("postrst_count", 32'(obs_q.size()), 32'd8);
      if (obs_q.size() == 8)
         for (int k = 0; k < 8; k++) check("postrst_beat", obs_q[k], pat(200 + k));

      // Random mixed traffic against the model.
      for (int i = 0; i < 600; i++)
         step($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, $urandom, $urandom);
      idle(20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
